// File: rtl/shadow_pkg.sv
// Shared types, widths and bit-twiddling helpers for the Shadow-32 decryption engine.
package shadow_pkg;

  localparam int SHADOW_BLOCK_W = 32;
  localparam int SHADOW_KEY_W   = 64;

  typedef enum logic [1:0] {
    IDLE,
    KEXP,
    ROUND,
    DONE
  } state_e;

  // Branch mixing function: (rotl1 & rotl7) ^ rotl2 on a byte.
  function automatic logic [7:0] f8(input logic [7:0] a);
    logic [7:0] r1, r7, r2;
    r1 = {a[6:0], a[7]};
    r7 = {a[0], a[7:1]};
    r2 = {a[5:0], a[7:6]};
    return (r1 & r7) ^ r2;
  endfunction

  function automatic logic [63:0] rotl64(input logic [63:0] x, input int unsigned n);
    int unsigned m;
    m = n % 64;
    if (m == 0) return x;
    return (x << m) | (x >> (64 - m));
  endfunction

  function automatic logic [63:0] rotr64(input logic [63:0] x, input int unsigned n);
    int unsigned m;
    m = n % 64;
    if (m == 0) return x;
    return (x >> m) | (x << (64 - m));
  endfunction

endpackage

// File: rtl/shadow_branch_inv.sv
// Combinational inverse of one Shadow-32 byte branch: (p,q,k) -> (a,b).
module shadow_branch_inv
  import shadow_pkg::*;
(
  input  logic [7:0] p_i,
  input  logic [7:0] q_i,
  input  logic [7:0] k_i,
  output logic [7:0] a_o,
  output logic [7:0] b_o
);

  assign a_o = q_i;
  assign b_o = p_i ^ f8(q_i) ^ k_i;

endmodule

// File: rtl/shadow_dec_core.sv
// Iterative Shadow-32 decryption engine, one byte branch per clock.
// Optional round-key cache enabled by defining SHADOW_DEC_KEYCACHE_EN.
module shadow_dec_core
  import shadow_pkg::*;
#(
  parameter int ROUNDS = 16
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [SHADOW_BLOCK_W-1:0] ct,
  input  logic [SHADOW_KEY_W-1:0]   key,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [SHADOW_BLOCK_W-1:0] pt,
  output logic                      busy
);

  localparam logic [4:0] LastRound = 5'(ROUNDS - 1);
  localparam logic [4:0] LastKexp  = 5'(ROUNDS - 2);

  state_e                    state_q;
  logic [SHADOW_BLOCK_W-1:0] s_q;
  logic [SHADOW_BLOCK_W-1:0] pt_q;
  logic [SHADOW_KEY_W-1:0]   kreg_q;
  logic [4:0]                kcnt_q;
  logic [4:0]                round_q;
  logic [1:0]                phase_q;
  // Intermediate bytes between half-rounds, packed as {v0,u0,v1,u1}.
  logic [31:0]               mid_q;

`ifdef SHADOW_DEC_KEYCACHE_EN
  logic                      cacheValid_q;
  logic [SHADOW_KEY_W-1:0]   cacheKey_q;
  logic [SHADOW_KEY_W-1:0]   cacheKexp_q;
  logic [SHADOW_KEY_W-1:0]   masterKey_q;
`endif

  logic [7:0] x0, y0, x1, y1;
  logic [7:0] brP, brQ, brK, brA, brB;
  logic [SHADOW_KEY_W-1:0] kregFwd_d, kregInv_d;

  assign kregFwd_d = rotl64(kreg_q, 3) ^ {59'b0, kcnt_q};
  assign kregInv_d = rotr64(kreg_q ^ {59'b0, round_q - 5'd1}, 3);

  // The last encryption round skips the cross-over, so it is undone first.
  always_comb begin
    x0 = '0; y0 = '0; x1 = '0; y1 = '0;
    if (round_q == LastRound) {x0, y0, x1, y1} = s_q;
    else                      {x1, y0, x0, y1} = s_q;
  end

  always_comb begin
    brP = '0; brQ = '0; brK = '0;
    unique case (phase_q)
      2'd0: begin brP = x0;           brQ = y0;           brK = kreg_q[47:40]; end
      2'd1: begin brP = x1;           brQ = y1;           brK = kreg_q[39:32]; end
      2'd2: begin brP = mid_q[23:16]; brQ = mid_q[31:24]; brK = kreg_q[63:56]; end
      2'd3: begin brP = mid_q[7:0];   brQ = mid_q[15:8];  brK = kreg_q[55:48]; end
    endcase
  end

  shadow_branch_inv uBranch (
    .p_i (brP),
    .q_i (brQ),
    .k_i (brK),
    .a_o (brA),
    .b_o (brB)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      s_q     <= '0;
      pt_q    <= '0;
      kreg_q  <= '0;
      kcnt_q  <= '0;
      round_q <= '0;
      phase_q <= '0;
      mid_q   <= '0;
`ifdef SHADOW_DEC_KEYCACHE_EN
      cacheValid_q <= 1'b0;
      cacheKey_q   <= '0;
      cacheKexp_q  <= '0;
      masterKey_q  <= '0;
`endif
    end else begin
      case (state_q)
        IDLE: begin
          if (in_valid) begin
            s_q     <= ct;
            kreg_q  <= key;
            kcnt_q  <= '0;
            round_q <= LastRound;
            phase_q <= '0;
            state_q <= KEXP;
`ifdef SHADOW_DEC_KEYCACHE_EN
            masterKey_q <= key;
            if (cacheValid_q && cacheKey_q == key) begin
              kreg_q  <= cacheKexp_q;
              state_q <= ROUND;
            end
`endif
          end
        end
        KEXP: begin
          kreg_q <= kregFwd_d;
          kcnt_q <= kcnt_q + 5'd1;
          if (kcnt_q == LastKexp) begin
            round_q <= LastRound;
            phase_q <= '0;
            state_q <= ROUND;
`ifdef SHADOW_DEC_KEYCACHE_EN
            cacheValid_q <= 1'b1;
            cacheKey_q   <= masterKey_q;
            cacheKexp_q  <= kregFwd_d;
`endif
          end
        end
        ROUND: begin
          phase_q <= phase_q + 2'd1;
          unique case (phase_q)
            2'd0: mid_q[31:16] <= {brA, brB};
            2'd1: mid_q[15:0]  <= {brA, brB};
            2'd2: s_q[31:16]   <= {brA, brB};
            2'd3: begin
              s_q[15:0] <= {brA, brB};
              if (round_q == 5'd0) begin
                pt_q    <= {s_q[31:16], brA, brB};
                state_q <= DONE;
              end else begin
                kreg_q  <= kregInv_d;
                round_q <= round_q - 5'd1;
              end
            end
          endcase
        end
        DONE: begin
          if (out_ready) state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign busy      = (state_q == KEXP) || (state_q == ROUND);
  assign pt        = pt_q;

endmodule

// File: tb/tb_shadow_dec_core.sv
// Scoreboard bench: plaintexts are encrypted by a reference model, then must come back out of shadow_dec_core.
module tb_shadow_dec_core;

  localparam int ROUNDS = 16;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] ct;
  logic [63:0] key;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] pt;
  logic        busy;

  typedef struct {
    logic [31:0] ptExp;
    int          acceptEdge;
    int          latExp;
  } exp_t;

  exp_t        sb[$];
  int          checks = 0;
  int          failures = 0;
  int          edgeCnt = 0;
  int          stallBudget = 0;
  bit          inDone = 0;
  bit          expectIdleNext = 0;
  logic [31:0] heldPt = '0;
  bit          cacheValid = 0;
  logic [63:0] cacheKey = '0;

  always #5 clk = ~clk;
  always @(posedge clk) edgeCnt++;

  shadow_dec_core #(.ROUNDS(ROUNDS)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .ct        (ct),
    .key       (key),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .pt        (pt),
    .busy      (busy)
  );

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  function automatic logic [7:0] fRef(input logic [7:0] a);
    logic [7:0] r1, r7, r2;
    r1 = 8'((a << 1) | (a >> 7));
    r7 = 8'((a << 7) | (a >> 1));
    r2 = 8'((a << 2) | (a >> 6));
    return (r1 & r7) ^ r2;
  endfunction

  // Forward cipher straight from the round description; the DUT must invert it.
  function automatic logic [31:0] encRef(input logic [31:0] p, input logic [63:0] k0);
    logic [31:0] x;
    logic [63:0] k;
    logic [7:0]  u0, v0, u1, v1, x0, y0, x1, y1;
    x = p;
    k = k0;
    for (int i = 0; i < ROUNDS; i++) begin
      v0 = x[31:24]; u0 = x[23:16] ^ fRef(x[31:24]) ^ k[63:56];
      v1 = x[15:8];  u1 = x[7:0]   ^ fRef(x[15:8])  ^ k[55:48];
      y0 = v0;       x0 = u0 ^ fRef(v0) ^ k[47:40];
      y1 = v1;       x1 = u1 ^ fRef(v1) ^ k[39:32];
      x = (i == ROUNDS - 1) ? {x0, y0, x1, y1} : {x1, y0, x0, y1};
      k = ((k << 3) | (k >> 61)) ^ 64'(i);
    end
    return x;
  endfunction

  // Monitor: pops the scoreboard on the first DONE cycle and drives out_ready.
  always @(negedge clk) begin
    exp_t e;
    if (rst) begin
      inDone = 0;
      expectIdleNext = 0;
      out_ready = 1'b0;
    end else begin
      if (expectIdleNext) begin
        checkOutput("in_ready_after_handshake", 64'(in_ready), 64'd1);
        checkOutput("out_valid_after_handshake", 64'(out_valid), 64'd0);
        expectIdleNext = 0;
      end
      if (out_valid) begin
        if (!inDone) begin
          if (sb.size() == 0) begin
            checkOutput("unexpected_output", 64'd1, 64'd0);
          end else begin
            e = sb.pop_front();
            checkOutput("plaintext", 64'(pt), 64'(e.ptExp));
            checkOutput("latency", 64'(edgeCnt - e.acceptEdge), 64'(e.latExp));
          end
          heldPt = pt;
          inDone = 1;
        end else begin
          checkOutput("pt_hold", 64'(pt), 64'(heldPt));
        end
        checkOutput("in_ready_in_done", 64'(in_ready), 64'd0);
        if (stallBudget > 0) begin
          out_ready = 1'b0;
          stallBudget--;
        end else begin
          out_ready = ($urandom_range(0, 3) != 0);
        end
        if (out_ready) begin
          expectIdleNext = 1;
          inDone = 0;
        end
      end else begin
        out_ready = $urandom_range(0, 1) != 0;
      end
    end
  end

  task automatic applyStimulus(input logic [31:0] p, input logic [63:0] k, output int acc, output bit hit);
    int n;
    logic [31:0] c;
    exp_t e;
    n = 0;
    c = encRef(p, k);
    hit = 0;
    @(negedge clk);
    while (!in_ready && n < 3000) begin
      in_valid = $urandom_range(0, 1) != 0;
      ct = $urandom;
      key = {$urandom, $urandom};
      @(negedge clk);
      n++;
    end
    if (!in_ready) begin
      in_valid = 1'b0;
      checkOutput("idle_timeout", 64'd0, 64'd1);
      acc = -1;
      return;
    end
    in_valid = 1'b1;
    ct = c;
    key = k;
    acc = edgeCnt + 1;
`ifdef SHADOW_DEC_KEYCACHE_EN
    hit = cacheValid && (cacheKey == k);
    cacheValid = 1;
    cacheKey = k;
`endif
    e.ptExp = p;
    e.acceptEdge = acc;
    e.latExp = hit ? 4 * ROUNDS : 5 * ROUNDS - 1;
    sb.push_back(e);
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (!(sb.size() == 0 && in_ready) && n < 3000) begin
      @(negedge clk);
      in_valid = !in_ready && ($urandom_range(0, 1) != 0);
      n++;
    end
    in_valid = 1'b0;
    if (n >= 3000) checkOutput("drain_timeout", 64'd0, 64'd1);
  endtask

  initial begin
    int acc;
    bit hit;
    int entry;
    logic [63:0] lastKey;
    in_valid = 1'b0;
    ct = '0;
    key = '0;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    checkOutput("reset_in_ready", 64'(in_ready), 64'd1);
    checkOutput("reset_out_valid", 64'(out_valid), 64'd0);
    checkOutput("reset_busy", 64'(busy), 64'd0);
    checkOutput("reset_pt", 64'(pt), 64'd0);
    rst = 1'b0;

    $display("[TB] zero round trip");
    applyStimulus(32'h0, 64'h0, acc, hit);
    drain();

    $display("[TB] repeated key");
    applyStimulus($urandom, 64'h0123456789ABCDEF, acc, hit);
    applyStimulus($urandom, 64'h0123456789ABCDEF, acc, hit);
    applyStimulus($urandom, 64'hFEDCBA9876543210, acc, hit);
    drain();

    $display("[TB] backpressure");
    stallBudget = 20;
    applyStimulus($urandom, {$urandom, $urandom}, acc, hit);
    drain();
    checkOutput("stall_consumed", 64'(stallBudget), 64'd0);

    $display("[TB] mid-operation reset");
    applyStimulus(32'hCAFEF00D, {$urandom, $urandom}, acc, hit);
    entry = hit ? 0 : ROUNDS - 1;
    while (edgeCnt < acc + entry + 4 * (ROUNDS - 1 - 7) + 2) begin
      @(negedge clk);
      in_valid = !in_ready && ($urandom_range(0, 1) != 0);
    end
    checkOutput("busy_before_reset", 64'(busy), 64'd1);
    in_valid = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    checkOutput("mid_reset_in_ready", 64'(in_ready), 64'd1);
    checkOutput("mid_reset_out_valid", 64'(out_valid), 64'd0);
    checkOutput("mid_reset_pt", 64'(pt), 64'd0);
    void'(sb.pop_back());
    cacheValid = 0;
    applyStimulus(32'h12345678, 64'h0F1E2D3C4B5A6978, acc, hit);
    drain();

    $display("[TB] random traffic");
    lastKey = {$urandom, $urandom};
    for (int i = 0; i < 150; i++) begin
      if ($urandom_range(0, 3) != 0) lastKey = {$urandom, $urandom};
      applyStimulus($urandom, lastKey, acc, hit);
    end
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  always @(posedge clk) begin
    if (edgeCnt > 60000) begin
      checks++;
      failures++;
      $display("[TB] FAIL watchdog actual=%0d expected<=60000", edgeCnt);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
    end
  end

endmodule
